// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and default
// run-control constants, also used by the processor-level bench.
package mips_run_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD_RST = 2'd1,
      RUN      = 2'd2,
      DONE     = 2'd3
   } run_state_e;

   localparam int DEF_RST_CYCLES  = 4;
   localparam int DEF_TIMEOUT     = 55000;
   localparam int DEF_STALL_LIMIT = 8;

endpackage : mips_run_pkg

// File: rtl/mips_pc_stall_det.sv
// Detects the `j .` halt loop: reports when pc has equalled its previous valid
// value for STALL_LIMIT consecutive valid cycles.
module mips_pc_stall_det #(
   parameter int PC_W        = 32,
   parameter int STALL_LIMIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            valid,
   input  logic [PC_W-1:0] pc,
   output logic            stalled
);

   localparam int MW = $clog2(STALL_LIMIT + 1);

   logic [PC_W-1:0] last_pc_q, last_pc_d;
   logic            have_last_q, have_last_d;
   logic [MW-1:0]   match_cnt_q, match_cnt_d;
   logic            match;

   always_comb begin
      last_pc_d   = last_pc_q;
      have_last_d = have_last_q;
      match_cnt_d = match_cnt_q;
      match       = valid && have_last_q && (pc == last_pc_q);
      // The STALL_LIMIT-th consecutive match flags this very cycle.
      stalled     = match && (match_cnt_q >= MW'(STALL_LIMIT - 1));
      if (clear) begin
         have_last_d = 1'b0;
         match_cnt_d = '0;
      end else if (valid) begin
         last_pc_d   = pc;
         have_last_d = 1'b1;
         if (!match)
            match_cnt_d = '0;
         else if (match_cnt_q != MW'(STALL_LIMIT))
            match_cnt_d = match_cnt_q + MW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_pc_q   <= '0;
         have_last_q <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         last_pc_q   <= last_pc_d;
         have_last_q <= have_last_d;
         match_cnt_q <= match_cnt_d;
      end
   end

endmodule : mips_pc_stall_det

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: sequences core reset, gates execution, counts
// RUN cycles and retired instructions, and decides halt or timeout.
module mips_run_ctrl
   import mips_run_pkg::*;
#(
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int STALL_LIMIT = DEF_STALL_LIMIT,
   parameter int PC_W        = 32,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PC_W-1:0]  core_pc,
   input  logic             core_retire,
   input  logic             core_halt,
   output logic             core_rst_n,
   output logic             core_en,
   output logic             running,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   localparam int         RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0]    RST_INIT   = RW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

   run_state_e       state_q, state_d;
   logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;
   logic             done_q, done_d;
   logic             timed_out_q, timed_out_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             core_en_q, core_en_d;
   logic             running_q, running_d;
   logic             stalled;
   logic             halt;
   logic             timeout;

   mips_pc_stall_det #(
      .PC_W        (PC_W),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_det (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != RUN),
      .valid   (state_q == RUN),
      .pc      (core_pc),
      .stalled (stalled)
   );

   // NOTE: combinational blocks use blocking '=' with every target defaulted first
   // (no latches); only always_ff uses non-blocking '<='.
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      cycle_d     = cycle_q;
      instr_d     = instr_q;
      done_d      = done_q;
      timed_out_d = timed_out_q;
      halt        = core_halt || stalled;
      timeout     = (cycle_q == TIMEOUT_M1);

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = HOLD_RST;
               rst_cnt_d   = RST_INIT;
               cycle_d     = '0;
               instr_d     = '0;
               done_d      = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         HOLD_RST: begin
            if (rst_cnt_q == '0)
               state_d = RUN;
            else
               rst_cnt_d = rst_cnt_q - RW'(1);
         end
         RUN: begin
            if (cycle_q != '1)
               cycle_d = cycle_q + CNT_W'(1);
            if (core_retire && (instr_q != '1))
               instr_d = instr_q + CNT_W'(1);
            // Halt takes priority so a same-cycle timeout leaves timed_out clear.
            if (halt) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (timeout) begin
               state_d     = DONE;
               done_d      = 1'b1;
               timed_out_d = 1'b1;
            end
         end
      endcase

      // Outputs are decoded from the next state so they are registered in step with it.
      core_rst_n_d = (state_d == RUN) || (state_d == DONE);
      core_en_d    = (state_d == HOLD_RST) || (state_d == RUN);
      running_d    = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         rst_cnt_q    <= '0;
         cycle_q      <= '0;
         instr_q      <= '0;
         done_q       <= 1'b0;
         timed_out_q  <= 1'b0;
         core_rst_n_q <= 1'b0;
         core_en_q    <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         cycle_q      <= cycle_d;
         instr_q      <= instr_d;
         done_q       <= done_d;
         timed_out_q  <= timed_out_d;
         core_rst_n_q <= core_rst_n_d;
         core_en_q    <= core_en_d;
         running_q    <= running_d;
      end
   end

   assign core_rst_n  = core_rst_n_q;
   assign core_en     = core_en_q;
   assign running     = running_q;
   assign done        = done_q;
   assign timed_out   = timed_out_q;
   assign cycle_count = cycle_q;
   assign instr_count = instr_q;

endmodule : mips_run_ctrl

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: per-run stimulus tables feed a reference model
// whose end-of-run prediction is checked by a monitor when done rises.
module tb_mips_run_ctrl;
   import mips_run_pkg::*;

   localparam int RST_CYCLES  = DEF_RST_CYCLES;
   localparam int TIMEOUT     = 120;
   localparam int STALL_LIMIT = DEF_STALL_LIMIT;
   localparam int PC_W        = 32;
   localparam int CNT_W       = 32;

   typedef struct {
      logic [CNT_W-1:0] cyc;
      logic [CNT_W-1:0] instr;
      logic             to;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [PC_W-1:0]  core_pc = '0;
   logic             core_retire = 1'b0;
   logic             core_halt = 1'b0;
   logic             core_rst_n, core_en, running, done, timed_out;
   logic [CNT_W-1:0] cycle_count, instr_count;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   logic done_prev = 1'b0;

   logic [PC_W-1:0] pc_a   [TIMEOUT];
   logic            ret_a  [TIMEOUT];
   logic            halt_a [TIMEOUT];

   always #5 clk = ~clk;

   mips_run_ctrl #(
      .RST_CYCLES  (RST_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .STALL_LIMIT (STALL_LIMIT),
      .PC_W        (PC_W),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .core_pc     (core_pc),
      .core_retire (core_retire),
      .core_halt   (core_halt),
      .core_rst_n  (core_rst_n),
      .core_en     (core_en),
      .running     (running),
      .done        (done),
      .timed_out   (timed_out),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: walk the run cycle by cycle; it ends on explicit halt, on a pc that
   // matches each of its STALL_LIMIT predecessors, or after TIMEOUT cycles.
   function automatic exp_t model();
      exp_t e;
      int   instr = 0;
      bit   held;
      e.cyc = '0; e.instr = '0; e.to = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
         instr += int'(ret_a[k]);
         held = (k >= STALL_LIMIT);
         for (int j = 1; j <= STALL_LIMIT && held; j++)
            if (pc_a[k-j] != pc_a[k]) held = 1'b0;
         if (halt_a[k] || held || (k + 1 == TIMEOUT)) begin
            e.cyc   = CNT_W'(k + 1);
            e.instr = CNT_W'(instr);
            e.to    = !(halt_a[k] || held);
            return e;
         end
      end
      return e;
   endfunction

   task automatic gen_random(input int rep_pct, input int halt_permil);
      pc_a[0] = PC_W'($urandom_range(0, 255) * 4);
      for (int k = 0; k < TIMEOUT; k++) begin
         ret_a[k]  = 1'($urandom_range(0, 1));
         halt_a[k] = ($urandom_range(0, 999) < halt_permil);
         if (k > 0)
            pc_a[k] = ($urandom_range(0, 99) < rep_pct) ? pc_a[k-1] : pc_a[k-1] + PC_W'(4);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Drives one run from IDLE/DONE using the current stimulus tables.
   task automatic run_once(input bit poke_start);
      exp_t e;
      int   k = 0;
      int   hold = 0;
      int   guard = 0;
      e = model();
      exp_q.push_back(e);
      pulse_start();
      check("restart_cleared", {done, timed_out, core_rst_n, cycle_count, instr_count}, '0);
      while (!running && guard < 20) begin
         if (!core_rst_n && core_en) hold++;
         @(posedge clk); #1;
         guard++;
      end
      check("hold_cycles", hold, RST_CYCLES);
      check("run_entry", {running, core_rst_n, core_en}, 3'b111);
      while (running && k < TIMEOUT) begin
         core_pc     = pc_a[k];
         core_retire = ret_a[k];
         core_halt   = halt_a[k];
         start       = poke_start && (k == 10);
         k++;
         @(posedge clk); #1;
      end
      core_retire = 1'b0;
      core_halt   = 1'b0;
      start       = 1'b0;
      check("run_ended", running, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("frozen_counts", {cycle_count, instr_count}, {e.cyc, e.instr});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no pending run");
         end else begin
            e = exp_q.pop_front();
            check("cycle_count", cycle_count, e.cyc);
            check("instr_count", instr_count, e.instr);
            check("timed_out", timed_out, e.to);
            check("done_outputs", {core_en, running, core_rst_n}, 3'b001);
         end
      end
      done_prev <= done;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      // Reset held with start asserted: everything stays at reset values.
      reset = 1'b0;
      start = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("reset_hold", {core_rst_n, core_en, running, done, timed_out, cycle_count, instr_count}, '0);
      end
      start = 1'b0;
      reset = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_after_reset", {core_rst_n, core_en, running, done}, 4'b0000);
      end

      // Explicit halt at RUN cycle 100 with a retire every cycle.
      for (int k = 0; k < TIMEOUT; k++) begin
         pc_a[k] = PC_W'(32'h100 + k * 4); ret_a[k] = 1'b1; halt_a[k] = (k == 99);
      end
      run_once(1'b0);

      // Stall halt: 20 incrementing PCs, then a `j .` loop at 0x40.
      for (int k = 0; k < TIMEOUT; k++) begin
         pc_a[k] = (k < 20) ? PC_W'(k * 4) : PC_W'(32'h40);
         ret_a[k] = 1'($urandom_range(0, 1)); halt_a[k] = 1'b0;
      end
      run_once(1'b0);

      // Timeout with the PC always changing.
      for (int k = 0; k < TIMEOUT; k++) begin
         pc_a[k] = PC_W'(k * 4); ret_a[k] = 1'($urandom_range(0, 1)); halt_a[k] = 1'b0;
      end
      run_once(1'b0);

      // Halt on the very cycle that would time out: halt wins.
      halt_a[TIMEOUT-1] = 1'b1;
      run_once(1'b0);

      // Randomized runs, one with a start pulse during RUN.
      for (int r = 0; r < 10; r++) begin
         case (r % 4)
            0: gen_random(0, 10);
            1: gen_random(50, 5);
            2: gen_random(85, 0);
            default: gen_random(95, 20);
         endcase
         run_once(r == 3);
      end

      // Abort: reset low in the middle of RUN returns to IDLE at that edge.
      for (int k = 0; k < TIMEOUT; k++) begin
         pc_a[k] = PC_W'(k * 4); ret_a[k] = 1'b1; halt_a[k] = 1'b0;
      end
      pulse_start();
      guard = 0;
      while (!running && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("abort_run_entry", running, 1'b1);
      for (int k = 0; k < 30; k++) begin
         core_pc = pc_a[k]; core_retire = 1'b1;
         @(posedge clk); #1;
      end
      check("abort_midrun_count", cycle_count, 30);
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort_reset", {core_rst_n, core_en, running, done, timed_out, cycle_count, instr_count}, '0);
      reset = 1'b1;
      core_retire = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_idle", {core_rst_n, core_en, running, done}, 4'b0000);

      repeat (2) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mips_run_ctrl
